// File: rtl/ascon_rand_gen_pkg.sv
// Shared parameters, helpers and FSM state type for the Ascon masking randomness generator.
package ascon_params;

  localparam int unsigned D             = 2;
  localparam int unsigned PAR           = 1;
  localparam int unsigned COL_SIZE      = 5;
  localparam int unsigned LFSR_WIDTH    = 31;
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001;
  localparam int unsigned CFG_FIBONACCI = 0;
  localparam int unsigned CFG_GALOIS    = 1;
  localparam int unsigned STEPS         = 4;
  localparam int unsigned WARMUP_CYCLES = 64;

  // Fresh bits per transfer: D shares per sbox bit plus the pairwise refresh terms.
  function automatic int unsigned calc_rand_width(input int unsigned d, input int unsigned par,
                                                  input int unsigned col);
    return d * col * par + ((d + 1) * d) / 2;
  endfunction

  function automatic int unsigned calc_n_lfsr(input int unsigned rw, input int unsigned lw);
    return (rw + lw - 1) / lw;
  endfunction

  localparam int unsigned RAND_WIDTH = calc_rand_width(D, PAR, COL_SIZE);
  localparam int unsigned N_LFSR     = calc_n_lfsr(RAND_WIDTH, LFSR_WIDTH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } rg_state_e;

endpackage

// File: rtl/ascon_rand_gen_lfsr.sv
// One LFSR (Fibonacci or Galois) advancing STEPS single-bit steps per adv pulse.
module ascon_lfsr #(
  parameter int unsigned WIDTH = ascon_params::LFSR_WIDTH,
  parameter logic [WIDTH-1:0] POLY = ascon_params::LFSR_POLY,
  parameter int unsigned CONFIG = ascon_params::CFG_FIBONACCI,
  parameter int unsigned STEPS = ascon_params::STEPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adv,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_nxt;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    if (CONFIG == ascon_params::CFG_GALOIS) begin
      return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);
    end
    return {s[WIDTH-2:0], ^(s & POLY)};
  endfunction

  // Unrolled multi-step advance.
  always_comb begin
    state_nxt = state;
    for (int i = 0; i < int'(STEPS); i++) begin
      state_nxt = step1(state_nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= load_val;
    end else if (adv) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/ascon_rand_gen.sv
// Randomness source for the masked Ascon round: seeded parallel LFSRs with warm-up and reseed.
module ascon_rand_gen #(
  parameter int unsigned D = ascon_params::D,
  parameter int unsigned PAR = ascon_params::PAR,
  parameter int unsigned COL_SIZE = ascon_params::COL_SIZE,
  parameter int unsigned LFSR_WIDTH = ascon_params::LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = ascon_params::LFSR_POLY,
  parameter int unsigned LFSR_CONFIG = ascon_params::CFG_FIBONACCI,
  parameter int unsigned STEPS = ascon_params::STEPS,
  parameter int unsigned WARMUP_CYCLES = ascon_params::WARMUP_CYCLES,
  localparam int unsigned RAND_WIDTH = ascon_params::calc_rand_width(D, PAR, COL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic                  seed_valid_i,
  output logic                  seed_ready_o,
  input  logic                  reseed_i,
  output logic [RAND_WIDTH-1:0] rand_o,
  output logic                  rand_valid_o,
  input  logic                  rand_ready_i,
  output logic                  busy_o
);

  import ascon_params::rg_state_e;
  import ascon_params::SEED;
  import ascon_params::WARMUP;
  import ascon_params::RUN;

  localparam int unsigned N_LFSR = ascon_params::calc_n_lfsr(RAND_WIDTH, LFSR_WIDTH);
  localparam int unsigned IDX_W  = (N_LFSR < 2) ? 1 : $clog2(N_LFSR);
  localparam int unsigned WARM_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
  localparam int unsigned CAT_W  = N_LFSR * LFSR_WIDTH;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_LFSR - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);

  rg_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic              load_c, adv_c;
  logic [LFSR_WIDTH-1:0] seed_fix_c;
  logic [LFSR_WIDTH-1:0] lfsr_state [N_LFSR];
  logic [CAT_W-1:0]  lfsr_cat;
  logic              unused_cat;

  // An all-zero seed would lock the LFSR, so substitute 1.
  assign seed_fix_c = (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;

  for (genvar g = 0; g < int'(N_LFSR); g++) begin : g_lfsr
    ascon_lfsr #(
      .WIDTH (LFSR_WIDTH),
      .POLY  (LFSR_POLY),
      .CONFIG(LFSR_CONFIG),
      .STEPS (STEPS)
    ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (load_c && (idx_q == IDX_W'(g))),
      .load_val(seed_fix_c),
      .adv     (adv_c),
      .state   (lfsr_state[g])
    );
    assign lfsr_cat[g*LFSR_WIDTH +: LFSR_WIDTH] = lfsr_state[g];
  end

  // LFSR0 lands in the LSBs; bits above RAND_WIDTH are dropped.
  assign rand_o     = lfsr_cat[RAND_WIDTH-1:0];
  assign unused_cat = ^lfsr_cat;

  // Next-state logic: seeding order, warm-up count, advance and reseed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    warm_d  = warm_q;
    load_c  = 1'b0;
    adv_c   = 1'b0;
    unique case (state_q)
      SEED: begin
        if (reseed_i) begin
          idx_d = '0;
        end else if (seed_valid_i) begin
          load_c = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            warm_d  = '0;
            state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WARMUP: begin
        if (reseed_i) begin
          state_d = SEED;
          idx_d   = '0;
        end else begin
          adv_c = 1'b1;
          if (warm_q == WARM_LAST) begin
            warm_d  = '0;
            state_d = RUN;
          end else begin
            warm_d = warm_q + WARM_W'(1);
          end
        end
      end
      RUN: begin
        if (reseed_i) begin
          state_d = SEED;
          idx_d   = '0;
        end else if (rand_ready_i) begin
          adv_c = 1'b1;
        end
      end
      default: begin
        state_d = SEED;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEED;
      idx_q        <= '0;
      warm_q       <= '0;
      rand_valid_o <= 1'b0;
      seed_ready_o <= 1'b1;
      busy_o       <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      warm_q       <= warm_d;
      rand_valid_o <= (state_d == RUN);
      seed_ready_o <= (state_d == SEED);
      busy_o       <= (state_d != RUN);
    end
  end

endmodule

// File: tb/tb_ascon_rand_gen.sv
// Directed bench for ascon_rand_gen: Fibonacci, Galois and two-LFSR configurations.
module tb_ascon_rand_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Fibonacci, STEPS=1, no warm-up, one LFSR
  logic [30:0] fib_seed;
  logic        fib_sv, fib_reseed, fib_ready;
  logic        fib_sready, fib_valid, fib_busy;
  logic [12:0] fib_rand;
  // Galois, STEPS=1, no warm-up
  logic [30:0] gal_seed;
  logic        gal_sv, gal_reseed, gal_ready;
  logic        gal_sready, gal_valid, gal_busy;
  logic [12:0] gal_rand;
  // PAR=4: two Fibonacci LFSRs, STEPS=4, warm-up 3
  logic [30:0] par_seed;
  logic        par_sv, par_reseed, par_ready;
  logic        par_sready, par_valid, par_busy;
  logic [42:0] par_rand;

  int n_assert = 0;
  int n_fail   = 0;

  ascon_rand_gen #(.STEPS(1), .WARMUP_CYCLES(0)) u_fib (
    .clk(clk), .rst(rst), .seed_i(fib_seed), .seed_valid_i(fib_sv), .seed_ready_o(fib_sready),
    .reseed_i(fib_reseed), .rand_o(fib_rand), .rand_valid_o(fib_valid),
    .rand_ready_i(fib_ready), .busy_o(fib_busy));

  ascon_rand_gen #(.LFSR_CONFIG(ascon_params::CFG_GALOIS), .STEPS(1), .WARMUP_CYCLES(0)) u_gal (
    .clk(clk), .rst(rst), .seed_i(gal_seed), .seed_valid_i(gal_sv), .seed_ready_o(gal_sready),
    .reseed_i(gal_reseed), .rand_o(gal_rand), .rand_valid_o(gal_valid),
    .rand_ready_i(gal_ready), .busy_o(gal_busy));

  ascon_rand_gen #(.PAR(4), .STEPS(4), .WARMUP_CYCLES(3)) u_par (
    .clk(clk), .rst(rst), .seed_i(par_seed), .seed_valid_i(par_sv), .seed_ready_o(par_sready),
    .reseed_i(par_reseed), .rand_o(par_rand), .rand_valid_o(par_valid),
    .rand_ready_i(par_ready), .busy_o(par_busy));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [42:0] exp_par;
    rst = 1'b1;
    fib_seed = '0; fib_sv = 1'b0; fib_reseed = 1'b0; fib_ready = 1'b0;
    gal_seed = '0; gal_sv = 1'b0; gal_reseed = 1'b0; gal_ready = 1'b0;
    par_seed = '0; par_sv = 1'b0; par_reseed = 1'b0; par_ready = 1'b0;
    #2;
    check("rst_fib_valid", 64'(fib_valid), 64'd0);
    check("rst_fib_sready", 64'(fib_sready), 64'd1);
    check("rst_fib_busy", 64'(fib_busy), 64'd1);
    check("rst_fib_rand", 64'(fib_rand), 64'd0);
    check("rst_par_rand", 64'(par_rand), 64'd0);
    #10;
    rst = 1'b0;
    tick();

    // Fibonacci single-step sequence from seed 1
    fib_seed = 31'h00000001; fib_sv = 1'b1;
    tick();
    fib_sv = 1'b0;
    check("fib_w0", 64'(fib_rand), 64'h001);
    check("fib_w0_valid", 64'(fib_valid), 64'd1);
    check("fib_w0_busy", 64'(fib_busy), 64'd0);
    fib_ready = 1'b1;
    tick();
    check("fib_w1", 64'(fib_rand), 64'h003);
    tick();
    check("fib_w2", 64'(fib_rand), 64'h007);

    // Back-pressure holds the word; stray seeds in RUN are ignored
    fib_ready = 1'b0;
    fib_seed = 31'h00000555; fib_sv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) fib_sv = 1'b0;
      check("hold_word", 64'(fib_rand), 64'h007);
      check("hold_valid", 64'(fib_valid), 64'd1);
    end
    fib_ready = 1'b1;
    tick();
    check("burst_w3", 64'(fib_rand), 64'h00F);
    tick();
    check("burst_w4", 64'(fib_rand), 64'h01F);
    tick();
    check("burst_w5", 64'(fib_rand), 64'h03F);

    // Reseed with concurrent handshake: word taken, no advance
    fib_reseed = 1'b1;
    tick();
    fib_reseed = 1'b0; fib_ready = 1'b0;
    check("reseed_valid", 64'(fib_valid), 64'd0);
    check("reseed_sready", 64'(fib_sready), 64'd1);
    check("reseed_busy", 64'(fib_busy), 64'd1);
    check("reseed_no_adv", 64'(fib_rand), 64'h03F);
    fib_seed = 31'h00000001; fib_sv = 1'b1;
    tick();
    fib_sv = 1'b0; fib_ready = 1'b1;
    check("replay_w0", 64'(fib_rand), 64'h001);
    tick();
    check("replay_w1", 64'(fib_rand), 64'h003);
    tick();
    check("replay_w2", 64'(fib_rand), 64'h007);
    fib_ready = 1'b0;

    // Galois: MSB set folds the tap mask back in
    gal_seed = 31'h40000000; gal_sv = 1'b1;
    tick();
    gal_sv = 1'b0;
    check("gal_w0", 64'(gal_rand), 64'h0000);
    check("gal_w0_valid", 64'(gal_valid), 64'd1);
    gal_ready = 1'b1;
    tick();
    check("gal_w1", 64'(gal_rand), 64'h0001);
    tick();
    check("gal_w2", 64'(gal_rand), 64'h0002);
    gal_ready = 1'b0;

    // Two LFSRs, zero seed substitution, warm-up latency
    par_seed = 31'h00000001; par_sv = 1'b1;
    tick();
    check("par_mid_seed_sready", 64'(par_sready), 64'd1);
    par_seed = 31'h00000000;
    tick();
    par_seed = 31'h7ABCDEF;
    check("par_warm_sready", 64'(par_sready), 64'd0);
    check("par_warm_busy0", 64'(par_busy), 64'd1);
    tick();
    tick();
    check("par_pre_run_busy", 64'(par_busy), 64'd1);
    check("par_pre_run_valid", 64'(par_valid), 64'd0);
    tick();
    par_sv = 1'b0;
    check("par_run_busy", 64'(par_busy), 64'd0);
    check("par_run_valid", 64'(par_valid), 64'd1);
    exp_par = {12'hFFF, 31'h00001FFF};
    check("par_word", 64'(par_rand), 64'(exp_par));

    // Asynchronous reset in the middle of warm-up
    par_reseed = 1'b1;
    tick();
    par_reseed = 1'b0;
    par_seed = 31'h00000002; par_sv = 1'b1;
    tick();
    par_seed = 31'h00000000;
    tick();
    par_sv = 1'b0;
    tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(par_valid), 64'd0);
    check("arst_sready", 64'(par_sready), 64'd1);
    check("arst_busy", 64'(par_busy), 64'd1);
    check("arst_rand", 64'(par_rand), 64'd0);
    #1;
    rst = 1'b0;
    tick();

    // Fresh seeding after reset starts again from LFSR0
    par_seed = 31'h00000002; par_sv = 1'b1;
    tick();
    par_seed = 31'h00000000;
    tick();
    par_sv = 1'b0;
    tick();
    tick();
    tick();
    check("par2_valid", 64'(par_valid), 64'd1);
    exp_par = {12'hFFF, 31'h00002000};
    check("par2_word", 64'(par_rand), 64'(exp_par));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
